// File: rtl/crc_calc_engine.sv
// Bit-serial CRC-16 engine: one byte per 9 cycles, MSB first, with a finalize step that applies XOR_OUT.
// Optional build macro CRC_COMPARE_EN adds crc_expected / crc_ok / crc_err result comparison.
module crc_calc_engine #(
  parameter int unsigned            DATA_W  = 8,
  parameter int unsigned            CRC_W   = 16,
  parameter logic [CRC_W-1:0]       POLY    = 16'h1021,
  parameter logic [CRC_W-1:0]       INIT    = 16'hFFFF,
  parameter logic [CRC_W-1:0]       XOR_OUT = 16'h0000
) (
  input  logic              clk50m,
  input  logic              rst_n,
  input  logic              crc_clear,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              data_last,
`ifdef CRC_COMPARE_EN
  input  logic [CRC_W-1:0]  crc_expected,
  output logic              crc_ok,
  output logic              crc_err,
`endif
  output logic              busy,
  output logic [CRC_W-1:0]  crc_out,
  output logic              crc_valid,
  output logic              overrun
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FINAL, S_DONE} state_t;

  state_t             state, state_next;
  logic [CRC_W-1:0]   crc, crc_step;
  logic [DATA_W-1:0]  shreg;
  logic [CNT_W-1:0]   cnt;
  logic               pending;
  logic               accept, collide, last_bit, fb;

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (crc_clear) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (data_valid)     state_next = S_SHIFT;
          else if (data_last) state_next = S_FINAL;
        end
        // A data_last arriving on the final shift cycle still counts as pending.
        S_SHIFT: if (last_bit) state_next = (pending || data_last) ? S_FINAL : S_IDLE;
        S_FINAL: state_next = S_DONE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    accept   = ((state == S_IDLE) || (state == S_DONE)) && data_valid;
    collide  = ((state == S_SHIFT) || (state == S_FINAL)) && data_valid;
    last_bit = (cnt == '0);
    fb       = crc[CRC_W-1] ^ shreg[cnt];
    crc_step = {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  end

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      crc       <= INIT;
      shreg     <= '0;
      cnt       <= '0;
      pending   <= 1'b0;
      crc_out   <= '0;
      crc_valid <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      busy <= (state_next == S_SHIFT) || (state_next == S_FINAL);
      if (crc_clear) begin
        crc       <= INIT;
        shreg     <= '0;
        cnt       <= '0;
        pending   <= 1'b0;
        crc_out   <= '0;
        crc_valid <= 1'b0;
        overrun   <= 1'b0;
      end else begin
        if (collide) overrun <= 1'b1;
        if (accept) begin
          shreg     <= data_in;
          cnt       <= CNT_W'(DATA_W - 1);
          pending   <= data_last;
          crc_valid <= 1'b0;
        end
        if (state == S_SHIFT) begin
          crc     <= crc_step;
          cnt     <= cnt - 1'b1;
          pending <= last_bit ? 1'b0 : (pending | data_last);
        end
        if (state == S_FINAL) begin
          crc_out   <= crc ^ XOR_OUT;
          crc_valid <= 1'b1;
        end
      end
    end
  end

`ifdef CRC_COMPARE_EN
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      crc_ok  <= 1'b0;
      crc_err <= 1'b0;
    end else if (crc_clear || accept) begin
      crc_ok  <= 1'b0;
      crc_err <= 1'b0;
    end else if (state == S_FINAL) begin
      crc_ok  <= ((crc ^ XOR_OUT) == crc_expected);
      crc_err <= ((crc ^ XOR_OUT) != crc_expected);
    end
  end
`endif

endmodule
